stream_mux_nx1: RTL and testbench

Parametrised N-input, W-bit streaming multiplexer. It is the successor to the combinational 2x1 mux.
- Arbitrates between N valid/ready input channels (round-robin by default).
- Locks the grant for a whole packet, delimited by a last flag.
- Drives one registered valid/ready output stage.
- Sits between multiple producers and a single shared consumer.

---
 rtl/stream_mux_nx1_pkg.sv | 17 +
 rtl/stream_mux_nx1_if.sv | 31 +++
 rtl/stream_mux_nx1_rr_arbiter.sv | 49 ++++
 rtl/stream_mux_nx1.sv | 126 ++++++++++++
 tb/tb_stream_mux_nx1.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/stream_mux_nx1_pkg.sv
// Shared types and helpers for the N-input streaming multiplexer.
package stream_mux_nx1_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_nx1_if.sv
// Producer/consumer handshake bundle for stream_mux_nx1; slave is the mux view.
interface stream_mux_nx1_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import stream_mux_nx1_pkg::*;

  localparam int SW = sel_width(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;
  logic           busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, busy
  );

endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational channel picker: round-robin from ptr, or fixed lowest-index
// priority when STREAM_MUX_FIXED_PRIO_EN is defined.
module rr_arbiter
  import stream_mux_nx1_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

`ifdef STREAM_MUX_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(i);
      end
    end
  end
`else
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_rot;

  // Rotating a doubled request vector puts req[(ptr+k) mod N] at bit k.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl >> ptr;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_any && w_rot[k]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'((32'(ptr) + k) % N);
      end
    end
  end
`endif

endmodule

// File: rtl/stream_mux_nx1.sv
// N-input packet-locking stream mux with one registered output stage.
// Optional macro STREAM_MUX_FIXED_PRIO_EN selects fixed-priority arbitration.
module stream_mux_nx1
  import stream_mux_nx1_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sel_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_nx1_if.slave   bus
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_gnt;
  logic [SW-1:0] w_ptr;
  logic [SW-1:0] w_arb_idx;
  logic          w_arb_any;
  logic [SW-1:0] w_idx;
  logic          w_grant_ok;
  logic          w_slot_free;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [W-1:0]  w_sel_data;
  logic          w_xfer;
  logic [N-1:0]  w_in_ready;
  logic          w_busy;

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic          r_out_last;
  logic [SW-1:0] r_out_sel;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [SW-1:0] r_ptr;
  assign w_ptr = r_ptr;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (w_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_any (w_arb_any)
  );

  assign w_slot_free = ~r_out_valid | bus.out_ready;
  assign w_idx       = (r_state == ST_LOCKED) ? r_gnt : w_arb_idx;
  assign w_grant_ok  = (r_state == ST_LOCKED) | w_arb_any;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (SW'(i) == w_idx) begin
        w_sel_valid = bus.in_valid[i];
        w_sel_last  = bus.in_last[i];
        w_sel_data  = bus.in_data[i*W +: W];
      end
    end
  end

  assign w_xfer = rst_n & w_grant_ok & w_slot_free & w_sel_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && !w_sel_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer &&  w_sel_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = '0;
    w_busy     = (r_state == ST_LOCKED);
    if (rst_n && w_slot_free && w_grant_ok) begin
      for (int unsigned i = 0; i < N; i++) begin
        w_in_ready[i] = (SW'(i) == w_idx);
      end
    end
  end

  // A new beat overrides the output-transfer clear, so out_valid stays high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_idx;
      if (r_state == ST_IDLE && !w_sel_last) r_gnt <= w_idx;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifndef STREAM_MUX_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_ptr <= '0;
    else if (w_xfer && w_sel_last) r_ptr <= SW'(wrap_inc(32'(w_idx), N));
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_sel   = r_out_sel;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Directed bench for stream_mux_nx1 (N=4, W=8) with hand-computed expectations.
module tb_stream_mux_nx1;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_nx1_if #(.N(N), .W(W)) bus ();

  stream_mux_nx1 #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned ch, input logic v, input logic [7:0] d, input logic l);
    bus.in_valid[ch]        = v;
    bus.in_data[ch*W +: W]  = d;
    bus.in_last[ch]         = l;
  endtask

  initial begin
    int exp_sel;

    // Reset held for two cycles with every channel requesting
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < N; i++) drive(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data),  0);
    chk("rst_out_sel",   32'(bus.out_sel),   0);
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    chk("rst_busy",      32'(bus.busy),      0);

    // Round-robin over single-beat packets, including the 3->0 wrap
    rst_n = 1'b1;
    #1;
    chk("first_in_ready", 32'(bus.in_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_valid", 32'(bus.out_valid), 1);
      chk("rr_sel",   32'(bus.out_sel),   k % 4);
      chk("rr_data",  32'(bus.out_data),  32'hA0 + (k % 4));
    end

    // Packet lock: ch1 three beats while ch2 waits
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(3, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b1, 8'h11, 1'b0);
    drive(2, 1'b1, 8'h22, 1'b1);
    #1;
    chk("lock_in_ready0", 32'(bus.in_ready), 32'h2);
    tick();
    chk("lock_b1_data", 32'(bus.out_data), 32'h11);
    chk("lock_b1_sel",  32'(bus.out_sel),  1);
    chk("lock_b1_last", 32'(bus.out_last), 0);
    chk("lock_b1_busy", 32'(bus.busy),     1);
    drive(1, 1'b1, 8'h12, 1'b0);
    tick();
    chk("lock_b2_data", 32'(bus.out_data), 32'h12);
    chk("lock_b2_busy", 32'(bus.busy),     1);
    drive(1, 1'b1, 8'h13, 1'b1);
    #1;
    chk("lock_in_ready2", 32'(bus.in_ready), 32'h2);
    tick();
    chk("lock_b3_data", 32'(bus.out_data), 32'h13);
    chk("lock_b3_last", 32'(bus.out_last), 1);
    chk("lock_b3_sel",  32'(bus.out_sel),  1);
    chk("lock_end_busy", 32'(bus.busy),    0);
    drive(1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("lock_ch2_sel",  32'(bus.out_sel),  2);
    chk("lock_ch2_data", 32'(bus.out_data), 32'h22);
    drive(2, 1'b0, 8'h00, 1'b0);

    // Back-pressure: ptr=3 here, ch0 is the only requester
    drive(0, 1'b1, 8'h55, 1'b1);
    tick();
    chk("bp_load_data", 32'(bus.out_data), 32'h55);
    chk("bp_load_sel",  32'(bus.out_sel),  0);
    bus.out_ready = 1'b0;
    drive(0, 1'b1, 8'h66, 1'b1);
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.out_valid), 1);
      chk("bp_hold_data",  32'(bus.out_data),  32'h55);
      chk("bp_hold_ready", 32'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp_next_valid", 32'(bus.out_valid), 1);
    chk("bp_next_data",  32'(bus.out_data),  32'h66);
    drive(0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("idle_no_req_ready", 32'(bus.in_ready), 0);
    tick();
    chk("drain_valid", 32'(bus.out_valid), 0);

    // Reset mid-packet: ptr=1, ch3 starts a 4-beat packet
    drive(3, 1'b1, 8'h31, 1'b0);
    #1;
    chk("mid_in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("mid_b1_data", 32'(bus.out_data), 32'h31);
    chk("mid_b1_busy", 32'(bus.busy),     1);
    drive(3, 1'b1, 8'h32, 1'b0);
    tick();
    chk("mid_b2_data", 32'(bus.out_data), 32'h32);
    rst_n = 1'b0;
    drive(3, 1'b1, 8'h33, 1'b0);
    drive(0, 1'b1, 8'h05, 1'b1);
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_busy",  32'(bus.busy),      0);
    chk("mid_rst_data",  32'(bus.out_data),  0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("post_rst_sel",  32'(bus.out_sel),  0);
    chk("post_rst_data", 32'(bus.out_data), 32'h05);

    // ch0 and ch2 continuously valid with single beats; ptr=1 here
    drive(3, 1'b0, 8'h00, 1'b0);
    drive(0, 1'b1, 8'hA0, 1'b1);
    drive(2, 1'b1, 8'hA2, 1'b1);
    for (int k = 0; k < 4; k++) begin
`ifdef STREAM_MUX_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = (k % 2 == 0) ? 2 : 0;
`endif
      tick();
      chk("pair_sel",  32'(bus.out_sel),  exp_sel);
      chk("pair_data", 32'(bus.out_data), 32'hA0 + exp_sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
